// File: rtl/syn_sram_arb_if.sv
// rtl/syn_sram_arb_if.sv - client and SRAM-driver signal bundle for syn_sram_arb
interface syn_sram_arb_if #(
    parameter int ADDR_W = 18
);
    logic              gpu_req;
    logic              gpu_wr;
    logic [ADDR_W-1:0] gpu_addr;
    logic [15:0]       gpu_wdata;
    logic [1:0]        gpu_be;
    logic              gpu_ack;
    logic              gpu_rd_valid;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_ack;
    logic              vga_rd_valid;

    logic [15:0]       rd_data;

    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_wr_data;
    logic [1:0]        sram_be;
    logic              sram_cs;
    logic              sram_rd_en;
    logic              sram_wr_en;
    logic [15:0]       sram_rd_data;

    modport slave (
        input  gpu_req, gpu_wr, gpu_addr, gpu_wdata, gpu_be,
        input  vga_req, vga_addr,
        input  sram_rd_data,
        output gpu_ack, gpu_rd_valid, vga_ack, vga_rd_valid, rd_data,
        output sram_addr, sram_wr_data, sram_be, sram_cs, sram_rd_en, sram_wr_en
    );

    modport master (
        output gpu_req, gpu_wr, gpu_addr, gpu_wdata, gpu_be,
        output vga_req, vga_addr,
        output sram_rd_data,
        input  gpu_ack, gpu_rd_valid, vga_ack, vga_rd_valid, rd_data,
        input  sram_addr, sram_wr_data, sram_be, sram_cs, sram_rd_en, sram_wr_en
    );
endinterface

// File: rtl/syn_sram_arb.sv
// rtl/syn_sram_arb.sv - GPU/VGA arbiter owning the SRAM command bus
module syn_sram_arb #(
    parameter int ADDR_W     = 18,
    parameter int RD_LAT     = 2,
    parameter int TURN_CYC   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk_ir,
    input  logic          rst_sync_l,
    syn_sram_arb_if.slave bus
);
    localparam int TW = (TURN_CYC < 1) ? 1 : $clog2(TURN_CYC + 1);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_TURN} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     turn_q, turn_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [1:0]        be_q;
    logic              cs_q, rd_en_q, wr_en_q;
    logic [1:0]        tag_q [RD_LAT+1];
    logic              gpu_rv_q, vga_rv_q;
    logic [15:0]       rd_data_q;

    logic gpu_win, vga_win, win_rd, blocked, grant;

    always_comb begin
        gpu_win  = bus.gpu_req && (!bus.vga_req || (starve_q == SW'(STARVE_MAX)));
        vga_win  = bus.vga_req && !gpu_win;
        win_rd   = vga_win || (gpu_win && !bus.gpu_wr);
        // A pending turnaround freezes reads; TURN additionally freezes writes.
        blocked  = (turn_q != '0) && (win_rd || (state_q == ST_TURN));
        grant    = rst_sync_l && (gpu_win || vga_win) && !blocked;

        state_d  = ST_IDLE;
        if (grant)
            state_d = ST_ISSUE;
        else if (gpu_win || vga_win)
            state_d = ST_TURN;

        turn_d = turn_q;
        if (grant && gpu_win && bus.gpu_wr)
            turn_d = TW'(TURN_CYC);
        else if (turn_q != '0)
            turn_d = turn_q - 1'b1;

        starve_d = starve_q;
        if (!bus.gpu_req || (grant && gpu_win))
            starve_d = '0;
        else if (grant && vga_win && (starve_q != SW'(STARVE_MAX)))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            state_q   <= ST_IDLE;
            turn_q    <= '0;
            starve_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            cs_q      <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= 2'b00;
            gpu_rv_q  <= 1'b0;
            vga_rv_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q  <= state_d;
            turn_q   <= turn_d;
            starve_q <= starve_d;
            cs_q     <= grant;
            rd_en_q  <= grant && win_rd;
            wr_en_q  <= grant && !win_rd;
            if (grant) begin
                addr_q <= gpu_win ? bus.gpu_addr : bus.vga_addr;
                be_q   <= gpu_win ? bus.gpu_be : 2'b11;
                if (gpu_win) wdata_q <= bus.gpu_wdata;
            end
            // Tag leaves the pipe in the cycle the driver presents read data.
            tag_q[0] <= {grant && gpu_win && !bus.gpu_wr, grant && vga_win};
            for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
            gpu_rv_q <= tag_q[RD_LAT][1];
            vga_rv_q <= tag_q[RD_LAT][0];
            if (tag_q[RD_LAT] != 2'b00) rd_data_q <= bus.sram_rd_data;
        end
    end

    assign bus.gpu_ack      = grant && gpu_win;
    assign bus.vga_ack      = grant && vga_win;
    assign bus.gpu_rd_valid = gpu_rv_q;
    assign bus.vga_rd_valid = vga_rv_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.sram_addr    = addr_q;
    assign bus.sram_wr_data = wdata_q;
    assign bus.sram_be      = be_q;
    assign bus.sram_cs      = cs_q;
    assign bus.sram_rd_en   = rd_en_q;
    assign bus.sram_wr_en   = wr_en_q;
endmodule

// File: tb/tb_syn_sram_arb.sv
// tb/tb_syn_sram_arb.sv - directed self-checking bench for syn_sram_arb
module tb_syn_sram_arb;
    logic clk_ir;
    logic rst_sync_l;
    int   ncheck;
    int   npass;

    syn_sram_arb_if #(.ADDR_W(18)) bus ();

    syn_sram_arb #(
        .ADDR_W(18), .RD_LAT(2), .TURN_CYC(1), .STARVE_MAX(4)
    ) dut (
        .clk_ir    (clk_ir),
        .rst_sync_l(rst_sync_l),
        .bus       (bus)
    );

    initial begin
        clk_ir = 1'b0;
        forever #5 clk_ir = ~clk_ir;
    end

    // SRAM driver model: two-cycle read latency, byte-enabled writes.
    logic [15:0]   mem [1024];
    logic [1023:0] wrote;
    logic [15:0]   p1, p2;

    function automatic logic [15:0] rd_word(input logic [9:0] a);
        return wrote[a] ? mem[a] : (16'h5A00 + {6'd0, a});
    endfunction

    always @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            wrote <= '0;
            p1    <= '0;
            p2    <= '0;
        end else begin
            if (bus.sram_cs && bus.sram_wr_en) begin
                mem[bus.sram_addr[9:0]] <= {
                    bus.sram_be[1] ? bus.sram_wr_data[15:8] : rd_word(bus.sram_addr[9:0])[15:8],
                    bus.sram_be[0] ? bus.sram_wr_data[7:0]  : rd_word(bus.sram_addr[9:0])[7:0]};
                wrote[bus.sram_addr[9:0]] <= 1'b1;
            end
            if (bus.sram_cs && bus.sram_rd_en) p1 <= rd_word(bus.sram_addr[9:0]);
            p2 <= p1;
        end
    end

    assign bus.sram_rd_data = p2;

    task automatic tick();
        @(posedge clk_ir);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncheck++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    logic [9:0] exp_gpu;

    initial begin
        ncheck = 0;
        npass  = 0;
        rst_sync_l    = 1'b0;
        bus.gpu_req   = 1'b0;
        bus.gpu_wr    = 1'b0;
        bus.gpu_addr  = '0;
        bus.gpu_wdata = '0;
        bus.gpu_be    = 2'b00;
        bus.vga_req   = 1'b1;
        bus.vga_addr  = 18'h00040;

        // Reset held with a VGA request pending
        tick();
        chk("rst_vga_ack", bus.vga_ack, 0);
        chk("rst_cs", bus.sram_cs, 0);
        tick();
        chk("rst_vga_ack2", bus.vga_ack, 0);
        chk("rst_cs2", bus.sram_cs, 0);
        chk("rst_rd_en", bus.sram_rd_en, 0);
        chk("rst_wr_en", bus.sram_wr_en, 0);
        chk("rst_addr", bus.sram_addr, 0);
        chk("rst_be", bus.sram_be, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_vga_rv", bus.vga_rd_valid, 0);
        chk("rst_gpu_rv", bus.gpu_rd_valid, 0);

        rst_sync_l = 1'b1;
        #1;
        chk("first_vga_ack", bus.vga_ack, 1);
        tick();
        bus.vga_req = 1'b0;
        chk("v_cs", bus.sram_cs, 1);
        chk("v_rd_en", bus.sram_rd_en, 1);
        chk("v_wr_en", bus.sram_wr_en, 0);
        chk("v_addr", bus.sram_addr, 32'h40);
        chk("v_be", bus.sram_be, 2'b11);
        tick();
        tick();
        chk("v_rv_early", bus.vga_rd_valid, 0);
        tick();
        chk("v_rv", bus.vga_rd_valid, 1);
        chk("v_rd_data", bus.rd_data, 16'h5A40);
        chk("v_gpu_rv", bus.gpu_rd_valid, 0);
        tick();
        chk("v_rv_done", bus.vga_rd_valid, 0);

        // GPU full write then read with turnaround
        bus.gpu_req   = 1'b1;
        bus.gpu_wr    = 1'b1;
        bus.gpu_addr  = 18'h00123;
        bus.gpu_wdata = 16'hBEEF;
        bus.gpu_be    = 2'b11;
        #1;
        chk("gw_ack", bus.gpu_ack, 1);
        chk("gw_vga_ack", bus.vga_ack, 0);
        tick();
        bus.gpu_wr = 1'b0;
        #1;
        chk("gw_cs", bus.sram_cs, 1);
        chk("gw_wr_en", bus.sram_wr_en, 1);
        chk("gw_rd_en", bus.sram_rd_en, 0);
        chk("gw_addr", bus.sram_addr, 32'h123);
        chk("gw_wdata", bus.sram_wr_data, 16'hBEEF);
        chk("gw_be", bus.sram_be, 2'b11);
        chk("turn_hold", bus.gpu_ack, 0);
        tick();
        chk("turn_idle_cs", bus.sram_cs, 0);
        chk("turn_grant", bus.gpu_ack, 1);
        tick();
        bus.gpu_req = 1'b0;
        chk("gr_cs", bus.sram_cs, 1);
        chk("gr_rd_en", bus.sram_rd_en, 1);
        chk("gr_wr_en", bus.sram_wr_en, 0);
        chk("gr_addr", bus.sram_addr, 32'h123);
        tick();
        tick();
        chk("gr_rv_early", bus.gpu_rd_valid, 0);
        tick();
        chk("gr_rv", bus.gpu_rd_valid, 1);
        chk("gr_rd_data", bus.rd_data, 16'hBEEF);
        chk("gr_vga_rv", bus.vga_rd_valid, 0);
        tick();
        chk("gr_rv_done", bus.gpu_rd_valid, 0);

        // Low-byte write and read back
        bus.gpu_req   = 1'b1;
        bus.gpu_wr    = 1'b1;
        bus.gpu_wdata = 16'h12AB;
        bus.gpu_be    = 2'b01;
        #1;
        chk("bw_ack", bus.gpu_ack, 1);
        tick();
        bus.gpu_wr = 1'b0;
        #1;
        chk("bw_be", bus.sram_be, 2'b01);
        chk("bw_wdata", bus.sram_wr_data, 16'h12AB);
        chk("bw_wr_en", bus.sram_wr_en, 1);
        chk("bw_turn_hold", bus.gpu_ack, 0);
        tick();
        chk("bw_turn_grant", bus.gpu_ack, 1);
        tick();
        bus.gpu_req = 1'b0;
        tick();
        tick();
        tick();
        chk("bw_rv", bus.gpu_rd_valid, 1);
        chk("bw_rd_data", bus.rd_data, 16'hBEAB);

        // Simultaneous GPU write and VGA read
        bus.gpu_req   = 1'b1;
        bus.gpu_wr    = 1'b1;
        bus.gpu_addr  = 18'h00200;
        bus.gpu_wdata = 16'h7777;
        bus.gpu_be    = 2'b11;
        bus.vga_req   = 1'b1;
        bus.vga_addr  = 18'h00041;
        #1;
        chk("sim_vga_ack", bus.vga_ack, 1);
        chk("sim_gpu_ack", bus.gpu_ack, 0);
        tick();
        bus.vga_req = 1'b0;
        #1;
        chk("sim_gpu_ack2", bus.gpu_ack, 1);
        chk("sim_rd_en", bus.sram_rd_en, 1);
        chk("sim_rd_addr", bus.sram_addr, 32'h41);
        tick();
        bus.gpu_req = 1'b0;
        chk("sim_wr_en", bus.sram_wr_en, 1);
        chk("sim_wr_cs", bus.sram_cs, 1);
        chk("sim_wr_addr", bus.sram_addr, 32'h200);
        tick();
        tick();
        chk("sim_vga_rv", bus.vga_rd_valid, 1);
        chk("sim_rd_data", bus.rd_data, 16'h5A41);
        tick();

        // Starvation bound: VGA x4 then GPU x1
        bus.vga_req  = 1'b1;
        bus.vga_addr = 18'h00050;
        bus.gpu_req  = 1'b1;
        bus.gpu_wr   = 1'b0;
        bus.gpu_addr = 18'h00060;
        exp_gpu      = 10'b1000010000;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("starve_gpu_%0d", i), bus.gpu_ack, exp_gpu[i]);
            chk($sformatf("starve_vga_%0d", i), bus.vga_ack, !exp_gpu[i]);
            tick();
        end
        bus.vga_req = 1'b0;
        bus.gpu_req = 1'b0;
        repeat (6) tick();

        // Reset two cycles after a VGA read ack
        bus.vga_req  = 1'b1;
        bus.vga_addr = 18'h00042;
        #1;
        chk("mr_ack", bus.vga_ack, 1);
        tick();
        bus.vga_req = 1'b0;
        tick();
        rst_sync_l  = 1'b0;
        bus.vga_req = 1'b1;
        #1;
        chk("mr_vga_ack", bus.vga_ack, 0);
        chk("mr_cs", bus.sram_cs, 0);
        chk("mr_rd_en", bus.sram_rd_en, 0);
        chk("mr_addr", bus.sram_addr, 0);
        chk("mr_wdata", bus.sram_wr_data, 0);
        chk("mr_be", bus.sram_be, 0);
        chk("mr_rd_data", bus.rd_data, 0);
        chk("mr_vga_rv", bus.vga_rd_valid, 0);
        chk("mr_gpu_rv", bus.gpu_rd_valid, 0);
        tick();
        bus.vga_req = 1'b0;
        rst_sync_l  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("mr_no_rv_%0d", i), bus.vga_rd_valid, 0);
            chk($sformatf("mr_idle_cs_%0d", i), bus.sram_cs, 0);
        end

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end
endmodule
